// File: rtl/fft16_bf_sched.sv
// Radix-4 butterfly sequencer for a 16-point in-place FFT.
// Define FFT_INV_EN to latch `inverse` per run and emit conjugate twiddles.
module fft16_bf_sched #(
  parameter int BF_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        inverse,
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] tw_exp,
  output logic        stage
);

  localparam int LAT = 1 + BF_LAT;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  state_t          state;
  logic [1:0]      b;
  logic [2:0]      cnt;
  logic [LAT-1:0]  pv;
  logic [15:0]     pa [LAT];
  logic [15:0]     pt [LAT];
  logic            inv_q;

`ifndef FFT_INV_EN
  logic unused_inv;
  assign unused_inv = inverse;
  assign inv_q      = 1'b0;
`endif

  // Stage 0 strides lanes by 4, stage 1 groups adjacent lanes.
  function automatic logic [15:0] lane_addr(
    input logic       s,
    input logic [1:0] bb
  );
    logic [15:0] a;
    logic [1:0]  kk;
    a = '0;
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      a[4*k +: 4] = s ? {bb, kk} : {kk, bb};
    end
    return a;
  endfunction

  function automatic logic [15:0] twid(
    input logic       s,
    input logic [1:0] bb,
    input logic       inv
  );
    logic [15:0] t;
    logic [1:0]  kk;
    logic [3:0]  e;
    t = '0;
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      e  = s ? 4'd0 : {2'b00, bb} * {2'b00, kk};
      if (inv) e = 4'd0 - e;
      t[4*k +: 4] = e;
    end
    return t;
  endfunction

  assign wr_en   = pv[LAT-1];
  assign wr_addr = pa[LAT-1];
  assign tw_exp  = pt[LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      b       <= '0;
      cnt     <= '0;
      stage   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      pv      <= '0;
      for (int i = 0; i < LAT; i++) begin
        pa[i] <= '0;
        pt[i] <= '0;
      end
`ifdef FFT_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      // stage/b/inv_q still describe the butterfly read this cycle
      pv[0] <= rd_en;
      pa[0] <= rd_addr;
      pt[0] <= twid(stage, b, inv_q);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pt[i] <= pt[i-1];
      end
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state   <= ISSUE;
            stage   <= 1'b0;
            b       <= 2'd0;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= lane_addr(1'b0, 2'd0);
`ifdef FFT_INV_EN
            inv_q   <= inverse;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          if (b == 2'd3) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            b       <= b + 2'd1;
            rd_en   <= 1'b1;
            rd_addr <= lane_addr(stage, b + 2'd1);
          end
        end
        DRAIN: begin
          if (cnt == 3'(LAT - 1)) begin
            if (!stage) begin
              state   <= ISSUE;
              stage   <= 1'b1;
              b       <= 2'd0;
              rd_en   <= 1'b1;
              rd_addr <= lane_addr(1'b1, 2'd0);
            end else begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_bf_sched.sv
// Self-checking bench for fft16_bf_sched against a schedule-level model.
// Model derives every strobe from the accept cycle and plain lane arithmetic.
module tb_fft16_bf_sched;

  localparam int BF_LAT = 1;
  localparam int LAT    = 1 + BF_LAT;
  localparam int TOT    = 2 * (4 + LAT) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        inverse = 1'b0;
  logic        busy, done, rd_en, wr_en, stage;
  logic [15:0] rd_addr, wr_addr, tw_exp;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int last_acc = -1000;
  logic last_inv = 1'b0;

  always #5 clk = ~clk;

  fft16_bf_sched #(.BF_LAT(BF_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .inverse(inverse),
    .busy(busy),
    .done(done),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .tw_exp(tw_exp),
    .stage(stage)
  );

  function automatic logic [15:0] addr_of(input int s, input int bb);
    logic [15:0] v = '0;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = 4'((s == 0) ? bb + 4 * k : 4 * bb + k);
    return v;
  endfunction

  function automatic logic [15:0] tw_of(input int s, input int bb,
                                        input logic inv);
    logic [15:0] v = '0;
    int e;
    for (int k = 0; k < 4; k++) begin
      e = (s == 0) ? (bb * k) % 16 : 0;
      if (inv) e = (16 - e) % 16;
      v[4*k +: 4] = 4'(e);
    end
    return v;
  endfunction

  function automatic logic [51:0] model(input int tt);
    int d;
    int rc;
    logic e_busy, e_done, e_rd, e_wr;
    logic [15:0] ra, wa, tw;
    d = tt - last_acc;
    e_rd = 0; e_wr = 0; ra = '0; wa = '0; tw = '0;
    e_busy = (d >= 1) && (d <= TOT - 1);
    e_done = (d == TOT);
    for (int s = 0; s < 2; s++)
      for (int bb = 0; bb < 4; bb++) begin
        rc = 1 + s * (4 + LAT) + bb;
        if (d == rc) begin
          e_rd = 1; ra = addr_of(s, bb);
        end
        if (d == rc + LAT) begin
          e_wr = 1; wa = addr_of(s, bb); tw = tw_of(s, bb, last_inv);
        end
      end
    return {e_busy, e_done, e_rd, ra, e_wr, wa, tw};
  endfunction

  function automatic logic [51:0] obs();
    return {busy, done, rd_en, rd_en ? rd_addr : 16'h0,
            wr_en, wr_en ? wr_addr : 16'h0, wr_en ? tw_exp : 16'h0};
  endfunction

  task automatic drive(input logic s, input logic iv, input logic r);
    start = s; inverse = iv; rst = r;
    if (r) last_acc = -1000;
    else if (s && (t - last_acc) >= TOT) begin
      last_acc = t;
`ifdef FFT_INV_EN
      last_inv = iv;
`else
      last_inv = 1'b0;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 1);
    tick();
    drive(1, 1, 1);
    tick();
    checks++;
    if (obs() !== 52'h0) begin
      errors++;
      $display("FAIL reset_out t=%0d got=%h exp=0", t, obs());
    end
    checks++;
    if (stage !== 1'b0) begin
      errors++;
      $display("FAIL reset_stage t=%0d got=%b exp=0", t, stage);
    end
    drive(0, 0, 0);
    tick();
    checks++;
    if (obs() !== model(t)) begin
      errors++;
      $display("FAIL reset_idle t=%0d got=%h exp=%h", t, obs(), model(t));
    end
  endtask

  task automatic test_single_fft();
    int a;
    logic [15:0] e_tw1;
    idle(16);
    a = t;
    drive(1, 1'($urandom), 0);
    e_tw1 = last_inv ? 16'hDEF0 : 16'h3210;
    for (int rel = 1; rel <= 16; rel++) begin
      tick();
      checks++;
      if (obs() !== model(t)) begin
        errors++;
        $display("FAIL single rel=%0d got=%h exp=%h", rel, obs(), model(t));
      end
      if (rel == 2) begin
        checks++;
        if (rd_addr !== 16'hD951) begin
          errors++;
          $display("FAIL s0_rd_b1 got=%h exp=d951", rd_addr);
        end
      end
      if (rel == 4) begin
        checks++;
        if ({wr_addr, tw_exp} !== {16'hD951, e_tw1}) begin
          errors++;
          $display("FAIL s0_wr_b1 got=%h/%h exp=d951/%h",
                   wr_addr, tw_exp, e_tw1);
        end
      end
      if (rel == 6 && !last_inv) begin
        checks++;
        if (tw_exp !== 16'h9630) begin
          errors++;
          $display("FAIL s0_tw_b3 got=%h exp=9630", tw_exp);
        end
      end
      if (rel == 8) begin
        checks++;
        if (rd_addr !== 16'h7654) begin
          errors++;
          $display("FAIL s1_rd_b1 got=%h exp=7654", rd_addr);
        end
      end
      if (rel == 10) begin
        checks++;
        if (tw_exp !== 16'h0000) begin
          errors++;
          $display("FAIL s1_tw_b1 got=%h exp=0000", tw_exp);
        end
      end
      if ((rel >= 1 && rel <= 4) || (rel >= 7 && rel <= 10)) begin
        checks++;
        if (stage !== (rel >= 7)) begin
          errors++;
          $display("FAIL stage rel=%0d got=%b exp=%b", rel, stage, rel >= 7);
        end
      end
      drive(0, 1'($urandom), 0);
    end
    if (a < 0) $display("unreachable");
  endtask

  task automatic test_back_to_back();
    int a;
    idle(16);
    a = t;
    for (int i = 0; i < 56; i++) begin
      drive(i < 40, 1'($urandom), 0);
      tick();
      checks++;
      if (obs() !== model(t)) begin
        errors++;
        $display("FAIL b2b t=%0d got=%h exp=%h", t, obs(), model(t));
      end
      if (t - a == TOT + 1) begin
        checks++;
        if (rd_en !== 1'b1) begin
          errors++;
          $display("FAIL b2b_nogap got=%b exp=1", rd_en);
        end
      end
    end
  endtask

  task automatic test_abort();
    idle(16);
    drive(1, 1'($urandom), 0);
    for (int rel = 1; rel <= 20; rel++) begin
      tick();
      if (rel == 6) begin
        checks++;
        if ({obs(), stage, rd_addr, wr_addr, tw_exp} !== '0) begin
          errors++;
          $display("FAIL abort_zero got=%h stage=%b", obs(), stage);
        end
      end
      if (rel > 6) begin
        checks++;
        if (wr_en !== 1'b0) begin
          errors++;
          $display("FAIL abort_wr rel=%0d got=%b exp=0", rel, wr_en);
        end
      end
      checks++;
      if (obs() !== model(t)) begin
        errors++;
        $display("FAIL abort rel=%0d got=%h exp=%h", rel, obs(), model(t));
      end
      drive(0, 0, rel == 5);
    end
  endtask

  task automatic test_random();
    idle(4);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, 1'($urandom),
            $urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (obs() !== model(t)) begin
        errors++;
        $display("FAIL random t=%0d got=%h exp=%h", t, obs(), model(t));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fft();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft16_bf_sched.md
Name: fft16_bf_sched

Overview:
- Sequencer for the shared radix-4 complex butterfly in the 16-point FFT.
- Runs one FFT as 2 radix-4 stages of 4 butterflies each, in place, over a 16-entry complex sample buffer with 1-cycle synchronous read.
- Generates buffer read/write addresses, twiddle exponents, and write enables aligned to the butterfly pipeline.
- Provides a start/busy/done handshake to the top-level FFT controller.

Parameters:
- BF_LAT, 1, butterfly plus twiddle-multiply pipeline depth in cycles (1..4).
- Derived LAT = 1 + BF_LAT: cycles from rd_en to the matching wr_en.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request one FFT; sampled only while busy=0
- inverse  in  1  IFFT mode; used only under FFT_INV_EN, ignored otherwise
- busy  out  1  high from the cycle after start is accepted through the last write
- done  out  1  one-cycle pulse, the cycle after the last write
- rd_en  out  1  buffer read strobe, one butterfly's 4 operands
- rd_addr  out  16  4 lane addresses; lane k at [4k+3:4k]
- wr_en  out  1  buffer write strobe for butterfly results
- wr_addr  out  16  4 lane write addresses, same packing
- tw_exp  out  16  twiddle exponent e per lane (W16^e), same packing, aligned with wr_en
- stage  out  1  stage of the butterfly currently being issued

Behaviour:
- Reset: all outputs 0, FSM to IDLE, write pipeline valids cleared. Applies mid-FFT too; no further writes from aborted work.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: start=1 -> ISSUE with stage=0, b=0. start while busy=1 is ignored.
- ISSUE: rd_en=1 every cycle for b=0..3, so 4 consecutive cycles per stage.
  - b==3 -> DRAIN.
- DRAIN: hold for exactly LAT cycles. Stage 0 then goes to ISSUE with stage=1, b=0; stage 1 goes to FIN.
  - Guarantees stage-1 reads follow all stage-0 writes.
- FIN: done=1 for one cycle, busy=0, -> IDLE. A start in the FIN cycle is accepted, so back-to-back FFTs are allowed.
- Stage 0 lane k address: b + 4k. Stage 1 lane k address: 4b + k.
- wr_en, wr_addr and tw_exp are rd_en, rd_addr and the twiddle computed at issue, delayed LAT cycles through a shift register.
- Twiddles:
  - Stage 0 lane k: e = (b*k) mod 16. Lane 0 is always 0.
  - Stage 1: all e = 0.
- Result is left in the buffer in digit-reversed order: X[4q+p] at address 4p+q. Reordering is the consumer's job.
- Timing with BF_LAT=1, start sampled at cycle 0:
  - stage-0 rd cycles 1-4, wr cycles 3-6
  - stage-1 rd cycles 7-10, wr cycles 9-12
  - done at cycle 13; busy high cycles 1-12
  - Total latency = 2*(4+LAT) + 1 cycles.
- busy=1 exactly while state is not IDLE or FIN.

Optional Feature:
- Macro FFT_INV_EN.
- Defined: inverse is latched when start is accepted and held for the whole FFT. When latched 1, every emitted nonzero e becomes (16 - e) mod 16, giving conjugate twiddles. Output scaling is not applied.
- Undefined: the inverse port exists but is ignored; twiddles are always forward.

Test Plan:
- Reset, then start pulse at cycle 0, BF_LAT=1:
  - rd_en high cycles 1-4 and 7-10; wr_en high cycles 3-6 and 9-12; done=1 at cycle 13 only; busy=1 cycles 1-12.
- Stage-0 addresses and twiddles:
  - cycle 2 (b=1): rd_addr=0xD951.
  - cycle 4 (b=1 write): wr_addr=0xD951, tw_exp=0x3210.
  - b=3 write: tw_exp=0x9630.
- Stage-1 addresses: cycle 8 (b=1): rd_addr=0x7654; the matching write has tw_exp=0x0000.
- Control robustness:
  - start held high through a whole FFT: exactly one run until FIN; the start in the FIN cycle begins a second run at the next cycle with no gap.
  - rst=1 at cycle 5: next cycle all outputs 0; no wr_en afterwards without a new start.
- With FFT_INV_EN and inverse=1 at start, b=1 stage-0 write: tw_exp=0xDEF0. Toggling inverse mid-run has no effect.
